// File: rtl/max_stream_ctrl.sv
// rtl/max_stream_ctrl.sv - per-frame running max/argmax over a valid/ready word stream
// Define MAX_TIE_LAST_EN to let equal words replace the stored max (latest position wins).
module max_stream_ctrl #(
  parameter int WIDTH     = 3,
  parameter int FRAME_LEN = 8,
  parameter int IDX_W     = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_max,
  output logic [IDX_W-1:0] out_idx
);

  localparam int CNT_W = IDX_W + 1;
  localparam logic [CNT_W-1:0] LAST_SLOT = CNT_W'(FRAME_LEN - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   max_q, max_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               in_ready_q, in_ready_d;
  logic               out_valid_q, out_valid_d;
  logic [WIDTH-1:0]   out_max_q, out_max_d;
  logic [IDX_W-1:0]   out_idx_q, out_idx_d;

  logic accept;
  logic take;
  logic replace;
  logic frame_end;

  assign accept = in_valid & in_ready_q;
  assign take   = out_valid_q & out_ready;

  // The single shared compare/select slice.
`ifdef MAX_TIE_LAST_EN
  assign replace = (in_data >= max_q);
`else
  assign replace = (in_data > max_q);
`endif

  assign frame_end = in_last | (cnt_q == LAST_SLOT);

  always_comb begin
    state_d     = state_q;
    max_d       = max_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    out_max_d   = out_max_q;
    out_idx_d   = out_idx_q;

    case (state_q)
      IDLE: begin
        if (accept) begin
          max_d = in_data;
          idx_d = '0;
          cnt_d = CNT_W'(1);
          if (in_last) begin
            state_d     = HOLD;
            in_ready_d  = 1'b0;
            out_valid_d = 1'b1;
            out_max_d   = in_data;
            out_idx_d   = '0;
          end else begin
            state_d = ACCUM;
          end
        end
      end

      ACCUM: begin
        if (accept) begin
          cnt_d = cnt_q + CNT_W'(1);
          if (replace) begin
            max_d = in_data;
            idx_d = cnt_q[IDX_W-1:0];
          end
          // Result registers are loaded straight from the select outcome so
          // out_valid can rise the cycle after the final accept.
          if (frame_end) begin
            state_d     = HOLD;
            in_ready_d  = 1'b0;
            out_valid_d = 1'b1;
            out_max_d   = replace ? in_data : max_q;
            out_idx_d   = replace ? cnt_q[IDX_W-1:0] : idx_q;
          end
        end
      end

      HOLD: begin
        if (take) begin
          state_d     = IDLE;
          in_ready_d  = 1'b1;
          out_valid_d = 1'b0;
          cnt_d       = '0;
        end
      end

      default: begin
        state_d     = IDLE;
        in_ready_d  = 1'b1;
        out_valid_d = 1'b0;
        cnt_d       = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      max_q       <= '0;
      idx_q       <= '0;
      cnt_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_max_q   <= '0;
      out_idx_q   <= '0;
    end else begin
      state_q     <= state_d;
      max_q       <= max_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_max_q   <= out_max_d;
      out_idx_q   <= out_idx_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_max   = out_max_q;
  assign out_idx   = out_idx_q;

endmodule

// File: tb/tb_max_stream_ctrl.sv
// tb/tb_max_stream_ctrl.sv - directed self-checking bench for max_stream_ctrl
module tb_max_stream_ctrl;

`ifdef MAX_TIE_LAST_EN
  localparam bit TIE_LAST = 1'b1;
`else
  localparam bit TIE_LAST = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [2:0] in_data = '0;
  logic       in_last = 1'b0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [2:0] out_max;
  logic [2:0] out_idx;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  max_stream_ctrl #(.WIDTH(3), .FRAME_LEN(8), .IDX_W(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_max   (out_max),
    .out_idx   (out_idx)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp)
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    else
      n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [2:0] d, input logic last);
    int n = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    while (!in_ready && n < 50) begin
      tick();
      n++;
    end
    if (!in_ready) check("send_timeout", {31'd0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic take_result();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  logic [2:0] f1 [8] = '{3'd2, 3'd5, 3'd1, 3'd7, 3'd3, 3'd7, 3'd0, 3'd4};

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    tick();
    tick();
    rst = 1'b0;
    check("rst_in_ready",  in_ready,  1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_max",   out_max,   0);
    check("rst_out_idx",   out_idx,   0);

    // Full-length frame, back to back, ties at value 7.
    for (int i = 0; i < 8; i++) begin
      send(f1[i], 1'b0);
      if (i == 6) check("f1_no_early_valid", out_valid, 0);
    end
    check("f1_valid",    out_valid, 1);
    check("f1_in_ready", in_ready,  0);
    check("f1_max",      out_max,   7);
    check("f1_idx",      out_idx,   TIE_LAST ? 5 : 3);
    take_result();
    check("f1_after_valid", out_valid, 0);
    check("f1_after_ready", in_ready,  1);

    // Early termination via in_last.
    send(3'd6, 1'b0);
    send(3'd4, 1'b0);
    send(3'd1, 1'b1);
    check("f2_valid", out_valid, 1);
    check("f2_max",   out_max,   6);
    check("f2_idx",   out_idx,   0);
    in_valid = 1'b1;
    in_data  = 3'd7;
    tick();
    tick();
    check("f2_hold_ready", in_ready, 0);
    check("f2_hold_max",   out_max,  6);
    in_valid = 1'b0;
    take_result();
    check("f2_after_ready", in_ready, 1);

    // Backpressure: result held for 5 stalled cycles plus the handshake cycle.
    send(3'd0, 1'b0);
    send(3'd3, 1'b0);
    send(3'd6, 1'b0);
    send(3'd2, 1'b1);
    for (int i = 0; i < 5; i++) begin
      check("bp_valid", out_valid, 1);
      check("bp_max",   out_max,   6);
      check("bp_idx",   out_idx,   2);
      check("bp_ready", in_ready,  0);
      tick();
    end
    check("bp_valid_last", out_valid, 1);
    take_result();
    check("bp_after_valid", out_valid, 0);
    check("bp_after_ready", in_ready,  1);

    // Reset mid-frame discards the partial frame.
    for (int i = 0; i < 4; i++) send(3'd7, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst_ready", in_ready,  1);
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_max",   out_max,   0);
    for (int i = 0; i < 8; i++) send(3'd0, 1'b0);
    check("zero_valid", out_valid, 1);
    check("zero_max",   out_max,   0);
    check("zero_idx",   out_idx,   TIE_LAST ? 7 : 0);

    // Reset while holding a result drops it.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("hold_rst_valid", out_valid, 0);
    check("hold_rst_ready", in_ready,  1);

    // in_last on the 8th word closes exactly one frame.
    for (int i = 0; i < 8; i++) send(3'((i + 1) % 8), i == 7);
    check("f8_valid", out_valid, 1);
    check("f8_max",   out_max,   7);
    check("f8_idx",   out_idx,   6);
    take_result();
    tick();
    tick();
    check("f8_no_second", out_valid, 0);
    check("f8_ready",     in_ready,  1);
    send(3'd5, 1'b0);
    send(3'd1, 1'b1);
    check("f8_next_valid", out_valid, 1);
    check("f8_next_max",   out_max,   5);
    check("f8_next_idx",   out_idx,   0);
    take_result();

    // in_valid gaps, with in_last asserted during gaps (must be ignored).
    for (int i = 0; i < 8; i++) begin
      send(3'd3, 1'b0);
      if (i != 7) begin
        in_last = 1'b1;
        tick();
        in_last = 1'b0;
        check("gap_valid", out_valid, 0);
      end
    end
    check("gap_done_valid", out_valid, 1);
    check("gap_max",        out_max,   3);
    check("gap_idx",        out_idx,   TIE_LAST ? 7 : 0);
    take_result();
    check("gap_after_ready", in_ready, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
